// File: rtl/pulse_splitter_n.sv
// pulse_splitter_n: splits input pulses to N_OUT channels with per-channel pending counters.
// Define PULSE_SPLITTER_COUNT_EN to add the per-channel out_count fire counters.
module pulse_splitter_n #(
  parameter int N_OUT  = 2,
  parameter int PEND_W = 3,
  localparam int PTR_W = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_pulse,
  input  logic               mode,
  input  logic [N_OUT-1:0]   out_ready,
  input  logic               ovf_clr,
  output logic [N_OUT-1:0]   out_pulse,
  output logic [N_OUT-1:0]   overflow,
  output logic [PTR_W-1:0]   rr_ptr
`ifdef PULSE_SPLITTER_COUNT_EN
  ,
  output logic [N_OUT*16-1:0] out_count
`endif
);
  logic [N_OUT-1:0][PEND_W-1:0] pend_q, pend_d;
  logic [N_OUT-1:0] inc, fire, ovf_ev, pulse_q, ovf_q, ovf_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  always_comb begin
    inc    = '0;
    fire   = '0;
    ovf_ev = '0;
    pend_d = pend_q;
    for (int i = 0; i < N_OUT; i++) begin
      inc[i]    = in_pulse & (~mode | (PTR_W'(i) == rr_q));
      fire[i]   = out_ready[i] & ((pend_q[i] != '0) | inc[i]);
      ovf_ev[i] = inc[i] & ~fire[i] & (pend_q[i] == '1);
      pend_d[i] = ovf_ev[i] ? pend_q[i] : pend_q[i] + PEND_W'(inc[i]) - PEND_W'(fire[i]);
    end
    ovf_d = (ovf_q & ~{N_OUT{ovf_clr}}) | ovf_ev;
    rr_d  = (mode & in_pulse) ? ((rr_q == PTR_W'(N_OUT - 1)) ? '0 : rr_q + 1'b1) : rr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      pulse_q <= '0;
      ovf_q   <= '0;
      rr_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= fire;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
    end
  end
  assign out_pulse = pulse_q;
  assign overflow  = ovf_q;
  assign rr_ptr    = rr_q;
`ifdef PULSE_SPLITTER_COUNT_EN
  logic [N_OUT-1:0][15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_q[i] + 16'(fire[i]);
  end
  assign out_count = cnt_q;
`endif
endmodule

// File: tb/tb_pulse_splitter_n.sv
// tb_pulse_splitter_n: directed scoreboard bench for pulse_splitter_n (N_OUT=4, PEND_W=3).
module tb_pulse_splitter_n;
  localparam int N = 4;
  localparam int PW = 3;
  logic clk = 0, rst_n = 0, in_pulse = 0, mode = 0, ovf_clr = 0;
  logic [N-1:0] out_ready = '1;
  logic [N-1:0] out_pulse, overflow;
  logic [1:0] rr_ptr;
`ifdef PULSE_SPLITTER_COUNT_EN
  logic [N*16-1:0] out_count;
`endif
  pulse_splitter_n #(.N_OUT(N), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .mode(mode), .out_ready(out_ready),
    .ovf_clr(ovf_clr), .out_pulse(out_pulse), .overflow(overflow), .rr_ptr(rr_ptr)
`ifdef PULSE_SPLITTER_COUNT_EN
    , .out_count(out_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] o;
    logic [1:0]   r;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int m_pend[N];
  int m_cnt[N];
  logic [N-1:0] m_ovf;
  int m_rr;
  int n1;
  logic [3:0] rr_seq [6];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic in, input logic md, input logic [N-1:0] rdy, input logic clr);
    exp_t e;
    logic [N-1:0] ev;
    in_pulse = in; mode = md; out_ready = rdy; ovf_clr = clr;
    ev = '0;
    e.p = '0;
    for (int i = 0; i < N; i++) begin
      bit inc, f;
      inc = in && (!md || i == m_rr);
      f = rdy[i] && (m_pend[i] > 0 || inc);
      e.p[i] = f;
      if (inc && !f && m_pend[i] == (1 << PW) - 1) ev[i] = 1'b1;
      else m_pend[i] = m_pend[i] + int'(inc) - int'(f);
      if (f) m_cnt[i] = (m_cnt[i] + 1) & 32'hffff;
    end
    m_ovf = (clr ? '0 : m_ovf) | ev;
    e.o = m_ovf;
    if (md && in) m_rr = (m_rr + 1) % N;
    e.r = 2'(m_rr);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pulse", 32'(out_pulse), 32'(e.p));
    chk("ovf", 32'(overflow), 32'(e.o));
    chk("rr", 32'(rr_ptr), 32'(e.r));
`ifdef PULSE_SPLITTER_COUNT_EN
    for (int i = 0; i < N; i++) chk("count", 32'(out_count[16*i+:16]), m_cnt[i]);
`endif
  endtask
  task automatic do_reset();
    rst_n = 0;
    in_pulse = 0; mode = 0; ovf_clr = 0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_cnt[i] = 0; end
    m_ovf = '0; m_rr = 0;
    q.delete();
    #1;
    chk("rst_pulse", 32'(out_pulse), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_rr", 32'(rr_ptr), 0);
`ifdef PULSE_SPLITTER_COUNT_EN
    chk("rst_count", 32'(out_count[31:0]), 0);
`endif
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001; rr_seq[5] = 4'b0010;
    do_reset();
    // broadcast: single pulse after idle cycles
    for (int i = 0; i < 4; i++) step(0, 0, '1, 0);
    step(1, 0, '1, 0);
    chk("bcast_hit", 32'(out_pulse), 32'hf);
    step(0, 0, '1, 0);
    chk("bcast_once", 32'(out_pulse), 0);
    // round-robin: six consecutive pulses
    for (int k = 0; k < 6; k++) begin
      step(1, 1, '1, 0);
      chk("rr_onehot", 32'(out_pulse), 32'(rr_seq[k]));
    end
    chk("rr_end", 32'(rr_ptr), 2);
    step(0, 0, '1, 0);
    // backpressure on channel 1
    for (int k = 0; k < 7; k++) step(1, 0, 4'b1101, 0);
    chk("bp_no_ovf", 32'(overflow), 0);
    step(1, 0, 4'b1101, 0);
    chk("bp_ovf", 32'(overflow), 32'h2);
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, '1, 0);
      n1 += int'(out_pulse[1]);
    end
    chk("bp_drain", n1, 7);
    // overflow clear, then clear coincident with a new overflow event
    step(0, 0, '1, 1);
    chk("clr", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) step(1, 0, 4'b1101, 0);
    step(0, 0, 4'b1101, 1);
    chk("clr2", 32'(overflow), 0);
    step(1, 0, 4'b1101, 1);
    chk("clr_vs_ovf", 32'(overflow), 32'h2);
    // async reset mid-burst with channel 0 holding three pulses
    for (int k = 0; k < 3; k++) step(1, 0, 4'b1100, 0);
    step(1, 1, 4'b1100, 0);
    #1;
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 0, '1, 0);
    chk("post_rst_idle", 32'(out_pulse), 0);
    step(1, 1, '1, 0);
    chk("post_rst_rr", 32'(out_pulse), 32'h1);
    step(0, 0, '1, 0);
`ifdef PULSE_SPLITTER_COUNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 0, '1, 0);
    chk("cnt5_ch0", 32'(out_count[15:0]), 5);
    chk("cnt5_ch1", 32'(out_count[31:16]), 5);
    do_reset();
    for (int k = 0; k < 65537; k++) step(1, 0, '1, 0);
    chk("wrap_ch0", 32'(out_count[15:0]), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
